// File: rtl/core_pkg.sv
// core_pkg: constants shared by the execute stage and its ALU.
//   ALU_*    : 4-bit ALU operation codes from the ALU operation decoder
//   FWD_*    : 2-bit operand forwarding selects from the hazard unit
//   DEF_*    : default datapath / register-index widths
package core_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_REG_AW = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // 2'b11 is not a distinct source; it falls back to the register value.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs and EX/MEM outputs of the execute stage.
//   master : pipeline side that drives the ID/EX slot and observes EX/MEM
//   slave  : the execute stage itself
interface ex_stage_if
    import core_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
);
    // ID/EX slot
    logic              in_valid;
    logic [3:0]        operation;
    logic              alu_src;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic [DATA_W-1:0] exmem_fwd_data;
    logic [DATA_W-1:0] memwb_fwd_data;
    logic [REG_AW-1:0] rd_in;
    logic              reg_write_in;
    logic              mem_read_in;
    logic              mem_write_in;
    logic              mem_to_reg_in;
    logic              branch_in;

    // EX/MEM slot
    logic              out_valid;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] branch_target;
    logic              branch_taken;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd_out;
    logic              reg_write_out;
    logic              mem_read_out;
    logic              mem_write_out;
    logic              mem_to_reg_out;
    logic              illegal_op;

    modport master (
        output in_valid, operation, alu_src, read_data1, read_data2, imm, pc,
               forward_a, forward_b, exmem_fwd_data, memwb_fwd_data, rd_in,
               reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in,
        input  out_valid, alu_result, zero, branch_target, branch_taken,
               store_data, rd_out, reg_write_out, mem_read_out, mem_write_out,
               mem_to_reg_out, illegal_op
    );

    modport slave (
        input  in_valid, operation, alu_src, read_data1, read_data2, imm, pc,
               forward_a, forward_b, exmem_fwd_data, memwb_fwd_data, rd_in,
               reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in,
        output out_valid, alu_result, zero, branch_target, branch_taken,
               store_data, rd_out, reg_write_out, mem_read_out, mem_write_out,
               mem_to_reg_out, illegal_op
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU for the execute stage.
//   a, b      : operands
//   operation : ALU op code (AND / OR / ADD / SUB)
//   result    : operation result, 0 for unsupported codes
//   zero      : result == 0
//   illegal   : operation code is not one of the supported four
module alu_core
    import core_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        operation,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (operation)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: illegal = 1'b1;
        endcase
    end

    // Taken on the final result so an unsupported op also reports zero.
    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: registered execute stage (forwarding, ALU, branch target, EX/MEM).
//   clk   : core clock, rising edge
//   reset : asynchronous active-high reset, clears every output
//   stall : hold the EX/MEM register
//   flush : load a bubble (all zeros) into EX/MEM; wins over stall
//   bus   : ID/EX inputs and EX/MEM outputs (ex_stage_if.slave)
module ex_stage
    import core_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    ex_stage_if.slave  bus
);

    logic [DATA_W-1:0] op_a, fwd_b, op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero, alu_illegal;
    logic [DATA_W-1:0] br_target;

    // Operand forwarding; 2'b11 falls back to the register file value.
    always_comb begin
        op_a = bus.read_data1;
        case (bus.forward_a)
            FWD_EXMEM: op_a = bus.exmem_fwd_data;
            FWD_MEMWB: op_a = bus.memwb_fwd_data;
            default:   op_a = bus.read_data1;
        endcase
    end

    always_comb begin
        fwd_b = bus.read_data2;
        case (bus.forward_b)
            FWD_EXMEM: fwd_b = bus.exmem_fwd_data;
            FWD_MEMWB: fwd_b = bus.memwb_fwd_data;
            default:   fwd_b = bus.read_data2;
        endcase
    end

    // store_data always takes fwd_b; only the ALU sees the immediate.
    assign op_b      = bus.alu_src ? bus.imm : fwd_b;
    assign br_target = bus.pc + (bus.imm << 1);

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .a         (op_a),
        .b         (op_b),
        .operation (bus.operation),
        .result    (alu_res),
        .zero      (alu_zero),
        .illegal   (alu_illegal)
    );

    // EX/MEM register
    logic              vld_q;
    logic [DATA_W-1:0] alu_result_q;
    logic              zero_q;
    logic [DATA_W-1:0] branch_target_q;
    logic              branch_taken_q;
    logic [DATA_W-1:0] store_data_q;
    logic [REG_AW-1:0] rd_q;
    logic              reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
    logic              illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            // Plain if-branch on flush keeps the priority reset > flush > stall.
            vld_q           <= 1'b0;
            alu_result_q    <= '0;
            zero_q          <= 1'b0;
            branch_target_q <= '0;
            branch_taken_q  <= 1'b0;
            store_data_q    <= '0;
            rd_q            <= '0;
            reg_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            illegal_q       <= 1'b0;
        end else if (!stall) begin
            // Control bits are gated by in_valid; data fields load regardless.
            vld_q           <= bus.in_valid;
            alu_result_q    <= alu_res;
            zero_q          <= alu_zero;
            branch_target_q <= br_target;
            branch_taken_q  <= bus.in_valid & bus.branch_in & alu_zero;
            store_data_q    <= fwd_b;
            rd_q            <= bus.rd_in;
            reg_write_q     <= bus.in_valid & bus.reg_write_in;
            mem_read_q      <= bus.in_valid & bus.mem_read_in;
            mem_write_q     <= bus.in_valid & bus.mem_write_in;
            mem_to_reg_q    <= bus.in_valid & bus.mem_to_reg_in;
            illegal_q       <= bus.in_valid & alu_illegal;
        end
    end

    assign bus.out_valid      = vld_q;
    assign bus.alu_result     = alu_result_q;
    assign bus.zero           = zero_q;
    assign bus.branch_target  = branch_target_q;
    assign bus.branch_taken   = branch_taken_q;
    assign bus.store_data     = store_data_q;
    assign bus.rd_out         = rd_q;
    assign bus.reg_write_out  = reg_write_q;
    assign bus.mem_read_out   = mem_read_q;
    assign bus.mem_write_out  = mem_write_q;
    assign bus.mem_to_reg_out = mem_to_reg_q;
    assign bus.illegal_op     = illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. Each applied cycle pushes the
// predicted EX/MEM contents; a monitor pops and compares after every edge.
module tb_ex_stage;

    localparam int W  = 64;
    localparam int AW = 5;

    typedef struct {
        logic          in_valid;
        logic [3:0]    operation;
        logic          alu_src;
        logic [W-1:0]  rd1, rd2, imm, pc, exm, mwb;
        logic [1:0]    fa, fb;
        logic [AW-1:0] rd;
        logic          rw, mr, mw, m2r, br;
        logic          stall, flush;
    } stim_t;

    typedef struct {
        logic          valid;
        logic [W-1:0]  alu;
        logic          zero;
        logic [W-1:0]  bt;
        logic          taken;
        logic [W-1:0]  sd;
        logic [AW-1:0] rd;
        logic          rw, mr, mw, m2r, ill;
        logic          dchk;   // data fields are meaningful (not a bubble)
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b1;
    logic flush = 1'b0;

    ex_stage_if #(.DATA_W(W), .REG_AW(AW)) bus ();

    ex_stage #(.DATA_W(W), .REG_AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];
    exp_t model;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t zero_state();
        exp_t z;
        z = '{valid:0, alu:'0, zero:0, bt:'0, taken:0, sd:'0, rd:'0,
              rw:0, mr:0, mw:0, m2r:0, ill:0, dchk:1};
        return z;
    endfunction

    function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] r,
                                         input logic [W-1:0] exm, input logic [W-1:0] mwb);
        if (sel == 2'b10) return exm;
        if (sel == 2'b01) return mwb;
        return r;
    endfunction

    // Reference: next EX/MEM contents from the stage rules.
    function automatic exp_t predict(input exp_t cur, input stim_t s);
        exp_t n;
        logic [W-1:0] a, fb, b, r;
        logic bad;
        if (s.flush) return zero_state();
        if (s.stall) return cur;
        a  = pick(s.fa, s.rd1, s.exm, s.mwb);
        fb = pick(s.fb, s.rd2, s.exm, s.mwb);
        b  = s.alu_src ? s.imm : fb;
        bad = 1'b0;
        case (s.operation)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd6: r = a - b;
            default: begin r = '0; bad = 1'b1; end
        endcase
        n.valid = s.in_valid;
        n.alu   = r;
        n.zero  = (r == 0);
        n.bt    = s.pc + s.imm * 2;
        n.taken = s.in_valid && s.br && (r == 0);
        n.sd    = fb;
        n.rd    = s.rd;
        n.rw    = s.in_valid & s.rw;
        n.mr    = s.in_valid & s.mr;
        n.mw    = s.in_valid & s.mw;
        n.m2r   = s.in_valid & s.m2r;
        n.ill   = s.in_valid & bad;
        n.dchk  = s.in_valid;
        return n;
    endfunction

    function automatic stim_t base();
        stim_t s;
        s = '{in_valid:1, operation:4'd2, alu_src:0, rd1:'0, rd2:'0, imm:'0, pc:'0,
              exm:'0, mwb:'0, fa:2'b00, fb:2'b00, rd:5'd1, rw:1, mr:0, mw:0, m2r:0,
              br:0, stall:0, flush:0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        @(negedge clk);
        bus.in_valid       = s.in_valid;
        bus.operation      = s.operation;
        bus.alu_src        = s.alu_src;
        bus.read_data1     = s.rd1;
        bus.read_data2     = s.rd2;
        bus.imm            = s.imm;
        bus.pc             = s.pc;
        bus.exmem_fwd_data = s.exm;
        bus.memwb_fwd_data = s.mwb;
        bus.forward_a      = s.fa;
        bus.forward_b      = s.fb;
        bus.rd_in          = s.rd;
        bus.reg_write_in   = s.rw;
        bus.mem_read_in    = s.mr;
        bus.mem_write_in   = s.mw;
        bus.mem_to_reg_in  = s.m2r;
        bus.branch_in      = s.br;
        stall              = s.stall;
        flush              = s.flush;
        model = predict(model, s);
        exp_q.push_back(model);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"},     W'(bus.out_valid),     '0);
        check({tag, ".alu_result"},    bus.alu_result,        '0);
        check({tag, ".zero"},          W'(bus.zero),          '0);
        check({tag, ".branch_target"}, bus.branch_target,     '0);
        check({tag, ".branch_taken"},  W'(bus.branch_taken),  '0);
        check({tag, ".store_data"},    bus.store_data,        '0);
        check({tag, ".rd_out"},        W'(bus.rd_out),        '0);
        check({tag, ".reg_write"},     W'(bus.reg_write_out), '0);
        check({tag, ".mem_write"},     W'(bus.mem_write_out), '0);
        check({tag, ".illegal_op"},    W'(bus.illegal_op),    '0);
    endtask

    // Monitor: compares the EX/MEM register one delta-safe step after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_valid",    W'(bus.out_valid),      W'(e.valid));
            check("reg_write",    W'(bus.reg_write_out),  W'(e.rw));
            check("mem_read",     W'(bus.mem_read_out),   W'(e.mr));
            check("mem_write",    W'(bus.mem_write_out),  W'(e.mw));
            check("mem_to_reg",   W'(bus.mem_to_reg_out), W'(e.m2r));
            check("branch_taken", W'(bus.branch_taken),   W'(e.taken));
            check("illegal_op",   W'(bus.illegal_op),     W'(e.ill));
            if (e.dchk) begin
                check("alu_result",    bus.alu_result,    e.alu);
                check("zero",          W'(bus.zero),      W'(e.zero));
                check("branch_target", bus.branch_target, e.bt);
                check("store_data",    bus.store_data,    e.sd);
                check("rd_out",        W'(bus.rd_out),    W'(e.rd));
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cyc;
        logic [3:0] ops [5];
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd6; ops[4] = 4'd0;

        s = base();
        s.stall = 1'b1;
        bus.in_valid = 0; bus.operation = 0; bus.alu_src = 0;
        bus.read_data1 = 0; bus.read_data2 = 0; bus.imm = 0; bus.pc = 0;
        bus.exmem_fwd_data = 0; bus.memwb_fwd_data = 0;
        bus.forward_a = 0; bus.forward_b = 0; bus.rd_in = 0;
        bus.reg_write_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0;
        bus.mem_to_reg_in = 0; bus.branch_in = 0;
        model = zero_state();

        // Reset held 3 cycles, released mid-cycle with the stage stalled.
        repeat (3) @(posedge clk);
        #2 check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        #1 check_all_zero("post_reset");

        // ADD 5 + 7
        s = base(); s.rd1 = 5; s.rd2 = 7; apply(s);
        // SUB 9 - 9, branch, pc 0x100, imm 0x10 -> target 0x120
        s = base(); s.operation = 4'd6; s.rd1 = 9; s.rd2 = 9; s.br = 1;
        s.pc = 64'h100; s.imm = 64'h10; apply(s);

        // Forwarding
        s = base(); s.rd1 = 1; s.rd2 = 3; s.exm = 64'h40; s.mwb = 64'h80;
        s.fa = 2'b10; apply(s);
        s.fa = 2'b01; apply(s);
        s.fa = 2'b11; apply(s);
        s.fa = 2'b00; s.fb = 2'b10; s.alu_src = 1; s.imm = 2; apply(s);

        // AND / OR / illegal op
        s = base(); s.operation = 4'd0; s.rd1 = 64'hF0; s.rd2 = 64'h3C; apply(s);
        s.operation = 4'd1; s.rd2 = 64'h0F; apply(s);
        s.operation = 4'b0101; s.br = 1; apply(s);

        // Stall holds, then stall+flush inserts a bubble
        s = base(); s.rd1 = 2; s.rd2 = 2; apply(s);
        s.stall = 1; s.rd1 = 64'h55; s.rd2 = 64'h77; apply(s);
        s.rd1 = 64'h99; s.operation = 4'd6; apply(s);
        s.flush = 1; apply(s);

        // Bubble input with control bits set
        s = base(); s.in_valid = 0; s.rw = 1; s.mw = 1; s.br = 1; s.operation = 4'd6;
        s.rd1 = 3; s.rd2 = 3; apply(s);

        // Reset asserted mid-stall clears at once
        s = base(); s.rd1 = 10; s.rd2 = 20; apply(s);
        s.stall = 1; apply(s);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        stall = 1'b1;
        exp_q.delete();
        model = zero_state();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            s.in_valid  = ($urandom_range(0, 7) != 0);
            s.operation = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 3)];
            s.alu_src   = 1'($urandom);
            s.rd1       = {$urandom, $urandom};
            s.rd2       = ($urandom_range(0, 3) == 0) ? s.rd1 : {$urandom, $urandom};
            s.imm       = {$urandom, $urandom};
            s.pc        = {$urandom, $urandom};
            s.exm       = {$urandom, $urandom};
            s.mwb       = {$urandom, $urandom};
            s.fa        = 2'($urandom);
            s.fb        = 2'($urandom);
            s.rd        = AW'($urandom);
            s.rw        = 1'($urandom);
            s.mr        = 1'($urandom);
            s.mw        = 1'($urandom);
            s.m2r       = 1'($urandom);
            s.br        = 1'($urandom);
            s.stall     = ($urandom_range(0, 4) == 0);
            s.flush     = ($urandom_range(0, 9) == 0);
            apply(s);
        end

        // Drain the scoreboard within a bounded number of cycles.
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
